ram_cmd_master: RTL and testbench

Command initiator for the single-port sync RAM command interface: converts simple host write/read requests into the RAM's 10-bit opcode+payload command sequence. It drives command words with a valid strobe, then collects the RAM's read-data/valid response and returns it to the host. It sits between host-side control logic and the RAM, acting as the issuing end of the same command protocol that the SPI slave otherwise drives.

---
 rtl/ram_cmd_master_if.sv | 28 ++
 rtl/ram_cmd_master.sv | 128 ++++++++++++
 tb/tb_ram_cmd_master.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_cmd_master_if.sv
// Host request/response and RAM command/response signals of ram_cmd_master.
// Handshakes: a request transfers on an edge with req_valid && req_ready. rsp_valid, cmd_valid and ram_tx_valid are single-cycle strobes with no backpressure.
interface ram_cmd_master_if #(
  parameter int ADDR_SIZE = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_wr;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [ADDR_SIZE-1:0] req_wdata;
  logic                 rsp_valid;
  logic [ADDR_SIZE-1:0] rsp_rdata;
  logic                 rsp_err;
  logic [ADDR_SIZE+1:0] cmd_din;
  logic                 cmd_valid;
  logic [ADDR_SIZE-1:0] ram_dout;
  logic                 ram_tx_valid;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, ram_dout, ram_tx_valid,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, cmd_din, cmd_valid
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, ram_dout, ram_tx_valid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, cmd_din, cmd_valid
  );
endinterface

// File: rtl/ram_cmd_master.sv
// Turns host write/read requests into the RAM opcode+payload command sequence
// and returns the RAM read data (or a timeout error) to the host.
module ram_cmd_master #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_cmd_master_if.master  bus,
  output logic [2:0]        state_dbg
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WADDR = 3'd1;
  localparam logic [2:0] WDATA = 3'd2;
  localparam logic [2:0] RADDR = 3'd3;
  localparam logic [2:0] RCMD  = 3'd4;
  localparam logic [2:0] RWAIT = 3'd5;
  localparam logic [2:0] RESP  = 3'd6;

  logic [2:0]           state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [ADDR_SIZE-1:0] wdata_q, wdata_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ADDR_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [ADDR_SIZE+1:0] cmd_din_q, cmd_din_d;
  logic                 cmd_valid_q, cmd_valid_d;

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          state_d = bus.req_wr ? WADDR : RADDR;
        end
      end
      WADDR: state_d = WDATA;
      WDATA: begin
        state_d     = RESP;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
      RADDR: state_d = RCMD;
      RCMD: begin
        state_d = RWAIT;
        cnt_d   = '0;
      end
      RWAIT: begin
        // A strobe on the final waiting cycle still wins over the timeout.
        if (bus.ram_tx_valid) begin
          state_d     = RESP;
          rsp_rdata_d = bus.ram_dout;
          rsp_err_d   = 1'b0;
        end else if (cnt_inc == TMO) begin
          state_d     = RESP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          cnt_d       = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    cmd_valid_d = 1'b0;
    cmd_din_d   = '0;
    case (state_d)
      WADDR: begin cmd_valid_d = 1'b1; cmd_din_d = {2'b00, addr_d};  end
      WDATA: begin cmd_valid_d = 1'b1; cmd_din_d = {2'b01, wdata_d}; end
      RADDR: begin cmd_valid_d = 1'b1; cmd_din_d = {2'b10, addr_d};  end
      RCMD:  begin cmd_valid_d = 1'b1; cmd_din_d = {2'b11, {ADDR_SIZE{1'b0}}}; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cmd_din_q   <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cmd_din_q   <= cmd_din_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.cmd_din   = cmd_din_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_ram_cmd_master.sv
// Directed bench for ram_cmd_master: vector table of single transactions plus
// hand-written reset, back-to-back and stray-strobe sequences, with a small RAM model.
module tb_ram_cmd_master;
  localparam int AW = 8;

  logic       clk;
  logic       rst_n;
  logic [2:0] state_dbg;
  int         n_checks;
  int         n_fail;

  ram_cmd_master_if #(.ADDR_SIZE(AW)) bus ();

  ram_cmd_master #(.ADDR_SIZE(AW), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required earlier", $time);
    $fatal(1);
  end

  // RAM model: registered read data, valid one cycle after the trigger is seen
  logic [AW-1:0] mem [256];
  logic [AW-1:0] waddr = '0;
  logic [AW-1:0] raddr = '0;
  logic [AW-1:0] model_dout = '0;
  logic          model_valid = 1'b0;
  logic          mute;
  logic          spurious;

  always @(posedge clk) begin
    model_valid <= bus.cmd_valid && (bus.cmd_din[AW+1:AW] == 2'b11) && !mute;
    model_dout  <= mem[raddr];
    if (bus.cmd_valid) begin
      case (bus.cmd_din[AW+1:AW])
        2'b00: waddr <= bus.cmd_din[AW-1:0];
        2'b01: mem[waddr] <= bus.cmd_din[AW-1:0];
        2'b10: raddr <= bus.cmd_din[AW-1:0];
        default: ;
      endcase
    end
  end

  assign bus.ram_tx_valid = model_valid | spurious;
  assign bus.ram_dout     = model_dout;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [AW-1:0] wdata;
    logic          mute;
    logic [AW+1:0] cmd0;
    logic [AW+1:0] cmd1;
    int            lat;
    logic [AW-1:0] rdata;
    logic          err;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: one full transaction from an idle, ready DUT
  task automatic do_txn(input vec_t v);
    int early;
    bus.req_valid = 1'b1;
    bus.req_wr    = v.wr;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    mute          = v.mute;
    step();
    check("e0_req_ready", 32'(bus.req_ready), 32'd0);
    check("e0_cmd_valid", 32'(bus.cmd_valid), 32'd1);
    check("e0_cmd_din", 32'(bus.cmd_din), 32'(v.cmd0));
    bus.req_valid = 1'b0;
    bus.req_wr    = ~v.wr;
    bus.req_addr  = ~v.addr;
    bus.req_wdata = ~v.wdata;
    step();
    check("e1_cmd_valid", 32'(bus.cmd_valid), 32'd1);
    check("e1_cmd_din", 32'(bus.cmd_din), 32'(v.cmd1));
    early = 0;
    for (int k = 1; k <= v.lat; k++) begin
      step();
      if (k < v.lat && bus.rsp_valid) early++;
    end
    check("early_rsp", 32'(early), 32'd0);
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_err", 32'(bus.rsp_err), 32'(v.err));
    check("rsp_rdata", 32'(bus.rsp_rdata), 32'(v.rdata));
    check("rsp_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    step();
    check("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("post_req_ready", 32'(bus.req_ready), 32'd1);
    mute = 1'b0;
  endtask

  initial begin
    int rsp_seen;
    n_checks = 0;
    n_fail   = 0;
    //          wr    addr   wdata  mute  cmd0     cmd1     lat rdata  err
    vecs[0] = '{1'b1, 8'h3C, 8'hA5, 1'b0, 10'h03C, 10'h1A5, 1,  8'h00, 1'b0};
    vecs[1] = '{1'b0, 8'h3C, 8'h00, 1'b0, 10'h23C, 10'h300, 2,  8'hA5, 1'b0};
    vecs[2] = '{1'b0, 8'h3C, 8'h00, 1'b1, 10'h23C, 10'h300, 16, 8'h00, 1'b1};
    vecs[3] = '{1'b1, 8'h44, 8'h99, 1'b0, 10'h044, 10'h199, 1,  8'h00, 1'b0};
    vecs[4] = '{1'b0, 8'h44, 8'h00, 1'b0, 10'h244, 10'h300, 2,  8'h99, 1'b0};
    vecs[5] = '{1'b1, 8'hFF, 8'h5A, 1'b0, 10'h0FF, 10'h15A, 1,  8'h00, 1'b0};
    vecs[6] = '{1'b0, 8'hFF, 8'h00, 1'b0, 10'h2FF, 10'h300, 2,  8'h5A, 1'b0};

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    mute          = 1'b0;
    spurious      = 1'b0;

    // reset state and release
    repeat (3) step();
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check("rst_cmd_din", 32'(bus.cmd_din), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_req_ready_before_edge", 32'(bus.req_ready), 32'd0);
    step();
    check("rel_req_ready", 32'(bus.req_ready), 32'd1);
    check("rel_cmd_valid", 32'(bus.cmd_valid), 32'd0);

    for (int i = 0; i < 7; i++) do_txn(vecs[i]);

    // back-to-back with req_valid held high
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = 8'h10;
    bus.req_wdata = 8'h55;
    step();
    check("b2b_e0_cmd", 32'(bus.cmd_din), 32'h010);
    check("b2b_e0_ready", 32'(bus.req_ready), 32'd0);
    bus.req_wr    = 1'b0;
    bus.req_wdata = 8'h00;
    step();
    check("b2b_e1_cmd", 32'(bus.cmd_din), 32'h155);
    step();
    check("b2b_wr_rsp", 32'(bus.rsp_valid), 32'd1);
    step();
    check("b2b_e3_ready", 32'(bus.req_ready), 32'd1);
    check("b2b_e3_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    step();
    check("b2b_e4_ready", 32'(bus.req_ready), 32'd0);
    check("b2b_e4_cmd", 32'(bus.cmd_din), 32'h210);
    bus.req_valid = 1'b0;
    step();
    check("b2b_e5_cmd", 32'(bus.cmd_din), 32'h300);
    step();
    check("b2b_e6_no_rsp", 32'(bus.rsp_valid), 32'd0);
    step();
    check("b2b_rd_rsp", 32'(bus.rsp_valid), 32'd1);
    check("b2b_rd_rdata", 32'(bus.rsp_rdata), 32'h55);
    step();
    check("b2b_end_ready", 32'(bus.req_ready), 32'd1);

    // asynchronous reset while in RCMD
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 8'h3C;
    step();
    bus.req_valid = 1'b0;
    step();
    check("rcmd_cmd_din", 32'(bus.cmd_din), 32'h300);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check("arst_cmd_din", 32'(bus.cmd_din), 32'd0);
    check("arst_req_ready", 32'(bus.req_ready), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    rsp_seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.rsp_valid) rsp_seen++;
    end
    check("arst_no_rsp", 32'(rsp_seen), 32'd0);
    check("arst_ready", 32'(bus.req_ready), 32'd1);
    do_txn(vecs[1]);

    // stray RAM strobe while idle must not touch the response
    do_txn(vecs[5]);
    spurious = 1'b1;
    repeat (3) step();
    spurious = 1'b0;
    step();
    check("stray_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("stray_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("stray_ready", 32'(bus.req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
